// File: rtl/fir_poly_mac_sched_if.sv
// Bus bundle between the polyphase FIR slot scheduler, the channel coefficient/data banks and the shared DSP.
// The slave modport is the scheduler's view; the master modport is the view from the banks and the DSP.
interface fir_poly_mac_sched_if #(
  parameter int M            = 20,
  parameter int M_LOG2       = 5,
  parameter int DSP_A_WIDTH  = 25,
  parameter int DSP_B_WIDTH  = 18,
  parameter int DSP_P_WIDTH  = 48,
  parameter int OUTPUT_WIDTH = 35
);
  logic                    sample_en;
  logic [DSP_A_WIDTH-1:0]  ch0_a;
  logic [DSP_A_WIDTH-1:0]  ch1_a;
  logic [DSP_B_WIDTH-1:0]  ch0_b;
  logic [DSP_B_WIDTH-1:0]  ch1_b;
  logic [DSP_P_WIDTH-1:0]  dsp_p;
  logic [M_LOG2-1:0]       tap_addr;
  logic                    ch_sel;
  logic                    mac_en;
  logic                    dsp_acc;
  logic [DSP_A_WIDTH-1:0]  dsp_a;
  logic [DSP_B_WIDTH-1:0]  dsp_b;
  logic [OUTPUT_WIDTH-1:0] ch0_dout;
  logic [OUTPUT_WIDTH-1:0] ch1_dout;
  logic                    ch0_valid;
  logic                    ch1_valid;
  logic                    overrun;

  modport slave (
    input  sample_en, ch0_a, ch1_a, ch0_b, ch1_b, dsp_p,
    output tap_addr, ch_sel, mac_en, dsp_acc, dsp_a, dsp_b,
           ch0_dout, ch1_dout, ch0_valid, ch1_valid, overrun
  );

  modport master (
    output sample_en, ch0_a, ch1_a, ch0_b, ch1_b, dsp_p,
    input  tap_addr, ch_sel, mac_en, dsp_acc, dsp_a, dsp_b,
           ch0_dout, ch1_dout, ch0_valid, ch1_valid, overrun
  );
endinterface

// File: rtl/fir_poly_mac_sched.sv
// Slot scheduler and shared-DSP arbiter for a 2-channel polyphase decimating FIR.
// Each sample period runs M slots: ch0 MACs, then ch1 MACs, then the results are captured after the DSP latency.
module fir_poly_mac_sched #(
  parameter int M            = 20,
  parameter int M_LOG2       = 5,
  parameter int K            = 6,
  parameter int DSP_LAT      = 3,
  parameter int DSP_A_WIDTH  = 25,
  parameter int DSP_B_WIDTH  = 18,
  parameter int DSP_P_WIDTH  = 48,
  parameter int OUTPUT_WIDTH = 35
) (
  input logic clk,
  input logic rst,
  fir_poly_mac_sched_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [M_LOG2-1:0] SLOT_LAST   = M_LOG2'(M - 1);
  localparam logic [M_LOG2-1:0] SLOT_K      = M_LOG2'(K);
  localparam logic [M_LOG2-1:0] SLOT_2K     = M_LOG2'(2 * K);
  localparam logic [M_LOG2-1:0] SLOT_K_LAST = M_LOG2'(K - 1);
  localparam logic [M_LOG2-1:0] SLOT_2K_LAST = M_LOG2'(2 * K - 1);

  state_t                  state_r;
  state_t                  state_nxt;
  logic [M_LOG2-1:0]       tap_addr_r;
  logic [M_LOG2-1:0]       tap_addr_nxt;
  logic                    overrun_s;
  logic                    mac_en_nxt;
  logic                    ch_sel_nxt;
  logic                    dsp_acc_nxt;
  logic                    mac_en_r;
  logic                    ch_sel_r;
  logic                    dsp_acc_r;
  logic                    overrun_r;
  logic                    tag0_in_s;
  logic                    tag1_in_s;
  logic [DSP_LAT-1:0]      tag0_r;
  logic [DSP_LAT-1:0]      tag1_r;
  logic [OUTPUT_WIDTH-1:0] ch0_dout_r;
  logic [OUTPUT_WIDTH-1:0] ch1_dout_r;
  logic                    ch0_valid_r;
  logic                    ch1_valid_r;

  // Period sequencing: a strobe at the last slot chains periods, earlier in a period it restarts and flags overrun.
  always_comb begin
    state_nxt    = state_r;
    tap_addr_nxt = tap_addr_r;
    overrun_s    = 1'b0;
    case (state_r)
      IDLE: begin
        tap_addr_nxt = '0;
        if (bus.sample_en) begin
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (tap_addr_r == SLOT_LAST) begin
          tap_addr_nxt = '0;
          state_nxt    = bus.sample_en ? RUN : IDLE;
        end else if (bus.sample_en) begin
          tap_addr_nxt = '0;
          overrun_s    = 1'b1;
        end else begin
          tap_addr_nxt = tap_addr_r + M_LOG2'(1);
        end
      end
      default: begin
        state_nxt    = IDLE;
        tap_addr_nxt = '0;
      end
    endcase
  end

  // Slot map decoded from the next slot so that the DSP controls are registered alongside tap_addr.
  always_comb begin
    mac_en_nxt  = 1'b0;
    ch_sel_nxt  = 1'b0;
    dsp_acc_nxt = 1'b0;
    if ((state_nxt == RUN) && (tap_addr_nxt < SLOT_2K)) begin
      mac_en_nxt  = 1'b1;
      ch_sel_nxt  = (tap_addr_nxt >= SLOT_K);
      dsp_acc_nxt = (tap_addr_nxt != '0) && (tap_addr_nxt != SLOT_K);
    end else begin
      mac_en_nxt  = 1'b0;
      ch_sel_nxt  = 1'b0;
      dsp_acc_nxt = 1'b0;
    end
  end

  assign tag0_in_s = (state_r == RUN) && (tap_addr_r == SLOT_K_LAST);
  assign tag1_in_s = (state_r == RUN) && (tap_addr_r == SLOT_2K_LAST);

  // Control state, slot counter and the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      tap_addr_r <= '0;
      mac_en_r   <= 1'b0;
      ch_sel_r   <= 1'b0;
      dsp_acc_r  <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      tap_addr_r <= tap_addr_nxt;
      mac_en_r   <= mac_en_nxt;
      ch_sel_r   <= ch_sel_nxt;
      dsp_acc_r  <= dsp_acc_nxt;
      overrun_r  <= overrun_r | overrun_s;
    end
  end

  // Tag delay line matches the DSP latency; a tag leaving it captures dsp_p for its channel.
  // An overrun drops every in-flight tag, including one exiting this very cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag0_r      <= '0;
      tag1_r      <= '0;
      ch0_dout_r  <= '0;
      ch1_dout_r  <= '0;
      ch0_valid_r <= 1'b0;
      ch1_valid_r <= 1'b0;
    end else if (overrun_s) begin
      tag0_r      <= '0;
      tag1_r      <= '0;
      ch0_valid_r <= 1'b0;
      ch1_valid_r <= 1'b0;
    end else begin
      tag0_r      <= (tag0_r << 1) | DSP_LAT'(tag0_in_s);
      tag1_r      <= (tag1_r << 1) | DSP_LAT'(tag1_in_s);
      ch0_valid_r <= tag0_r[DSP_LAT-1];
      ch1_valid_r <= tag1_r[DSP_LAT-1];
      if (tag0_r[DSP_LAT-1]) begin
        ch0_dout_r <= bus.dsp_p[OUTPUT_WIDTH-1:0];
      end else begin
        ch0_dout_r <= ch0_dout_r;
      end
      if (tag1_r[DSP_LAT-1]) begin
        ch1_dout_r <= bus.dsp_p[OUTPUT_WIDTH-1:0];
      end else begin
        ch1_dout_r <= ch1_dout_r;
      end
    end
  end

  assign bus.tap_addr  = tap_addr_r;
  assign bus.ch_sel    = ch_sel_r;
  assign bus.mac_en    = mac_en_r;
  assign bus.dsp_acc   = dsp_acc_r;
  assign bus.dsp_a     = mac_en_r ? (ch_sel_r ? bus.ch1_a : bus.ch0_a) : '0;
  assign bus.dsp_b     = mac_en_r ? (ch_sel_r ? bus.ch1_b : bus.ch0_b) : '0;
  assign bus.ch0_dout  = ch0_dout_r;
  assign bus.ch1_dout  = ch1_dout_r;
  assign bus.ch0_valid = ch0_valid_r;
  assign bus.ch1_valid = ch1_valid_r;
  assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_fir_poly_mac_sched.sv
// Bench for fir_poly_mac_sched: directed scenarios plus random strobes/resets/operands, compared
// cycle by cycle against a period-timing model built from slot arithmetic.
module tb_fir_poly_mac_sched;

  localparam int M   = 20;
  localparam int K   = 6;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst;

  fir_poly_mac_sched_if bus ();

  fir_poly_mac_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // External DSP: product/accumulate stage followed by two pipeline registers (3 cycles total).
  logic [47:0] acc_m = '0;
  logic [47:0] d1_m  = '0;

  function automatic logic [47:0] mul48(input logic [24:0] a, input logic [17:0] b);
    longint prod;
    prod = longint'($signed(a)) * longint'($signed(b));
    return prod[47:0];
  endfunction

  always @(posedge clk) begin
    if (bus.dsp_acc) acc_m <= acc_m + mul48(bus.dsp_a, bus.dsp_b);
    else             acc_m <= mul48(bus.dsp_a, bus.dsp_b);
    d1_m      <= acc_m;
    bus.dsp_p <= d1_m;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model state
  int          cyc    = 0;
  bit          have_p = 1'b0;
  int          p      = 0;
  bit          ov     = 1'b0;
  longint      sum0   = 0;
  longint      sum1   = 0;
  logic [34:0] exp_d0 = '0;
  logic [34:0] exp_d1 = '0;
  int          nv0    = 0;
  int          nv1    = 0;

  task automatic step(input bit se, input bit r,
                      input logic [24:0] a0, input logic [17:0] b0,
                      input logic [24:0] a1, input logic [17:0] b1);
    int          slot;
    bit          act;
    bit          ev0;
    bit          ev1;
    logic [24:0] ea;
    logic [17:0] eb;
    rst           = r;
    bus.sample_en = se;
    bus.ch0_a     = a0;
    bus.ch0_b     = b0;
    bus.ch1_a     = a1;
    bus.ch1_b     = b1;
    @(negedge clk);
    slot = cyc - p - 1;
    act  = have_p && (slot >= 0) && (slot < M);
    ev0  = have_p && (cyc == p + K + LAT + 1);
    ev1  = have_p && (cyc == p + 2 * K + LAT + 1);
    if (ev0) exp_d0 = sum0[34:0];
    if (ev1) exp_d1 = sum1[34:0];
    ea = '0;
    eb = '0;
    if (act && slot < K) begin
      ea = a0; eb = b0;
    end else if (act && slot < 2 * K) begin
      ea = a1; eb = b1;
    end
    check_eq("tap_addr",  64'(bus.tap_addr), act ? 64'(slot) : 64'd0);
    check_eq("mac_en",    64'(bus.mac_en),   64'(act && slot < 2 * K));
    check_eq("ch_sel",    64'(bus.ch_sel),   64'(act && slot >= K && slot < 2 * K));
    check_eq("dsp_acc",   64'(bus.dsp_acc),  64'(act && slot < 2 * K && slot != 0 && slot != K));
    check_eq("dsp_a",     64'(bus.dsp_a),    64'(ea));
    check_eq("dsp_b",     64'(bus.dsp_b),    64'(eb));
    check_eq("ch0_valid", 64'(bus.ch0_valid), 64'(ev0));
    check_eq("ch1_valid", 64'(bus.ch1_valid), 64'(ev1));
    check_eq("ch0_dout",  64'(bus.ch0_dout), 64'(exp_d0));
    check_eq("ch1_dout",  64'(bus.ch1_dout), 64'(exp_d1));
    check_eq("overrun",   64'(bus.overrun),  64'(ov));
    if (bus.ch0_valid === 1'b1) nv0++;
    if (bus.ch1_valid === 1'b1) nv1++;
    if (r) begin
      have_p = 1'b0;
      ov     = 1'b0;
      exp_d0 = '0;
      exp_d1 = '0;
    end else begin
      if (act && slot < K)
        sum0 = ((slot == 0) ? 64'sd0 : sum0) + longint'($signed(a0)) * longint'($signed(b0));
      else if (act && slot < 2 * K)
        sum1 = ((slot == K) ? 64'sd0 : sum1) + longint'($signed(a1)) * longint'($signed(b1));
      if (se) begin
        if (act && slot != M - 1) ov = 1'b1;
        p      = cyc;
        have_p = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst           = 1'b1;
    bus.sample_en = 1'b0;
    bus.ch0_a     = '0;
    bus.ch0_b     = '0;
    bus.ch1_a     = '0;
    bus.ch1_b     = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 25'd0, 18'd0, 25'd0, 18'd0);

    // Basic period with constant operands, then idle
    for (int i = 0; i < 30; i++) step(i == 0, 1'b0, 25'd1, 18'd2, 25'd3, 18'h3FFFF);
    check_eq("tp_ch0_dout_12",  64'($signed(bus.ch0_dout)), 64'sd12);
    check_eq("tp_ch1_dout_m18", 64'($signed(bus.ch1_dout)), -64'sd18);
    check_eq("tp_idle_mac_en",  64'(bus.mac_en), 64'd0);

    // Back-to-back periods
    nv0 = 0; nv1 = 0;
    for (int i = 0; i < 65; i++)
      step((i % 20 == 0) && (i <= 40), 1'b0, 25'($urandom), 18'($urandom), 25'($urandom), 18'($urandom));
    check_eq("b2b_ch0_valids", 64'(nv0), 64'd3);
    check_eq("b2b_ch1_valids", 64'(nv1), 64'd3);
    check_eq("b2b_overrun",    64'(bus.overrun), 64'd0);

    // Overrun: second strobe at relative cycle 8
    nv0 = 0; nv1 = 0;
    for (int i = 0; i < 35; i++)
      step((i == 0) || (i == 8), 1'b0, 25'($urandom), 18'($urandom), 25'($urandom), 18'($urandom));
    check_eq("ovr_flag",       64'(bus.overrun), 64'd1);
    check_eq("ovr_ch0_valids", 64'(nv0), 64'd1);
    check_eq("ovr_ch1_valids", 64'(nv1), 64'd1);

    // Reset in the middle of a period
    step(1'b0, 1'b1, 25'd0, 18'd0, 25'd0, 18'd0);
    nv0 = 0; nv1 = 0;
    for (int i = 0; i < 26; i++)
      step(i == 0, i == 5, 25'($urandom), 18'($urandom), 25'($urandom), 18'($urandom));
    check_eq("rst_ch0_valids", 64'(nv0), 64'd0);
    check_eq("rst_ch1_valids", 64'(nv1), 64'd0);
    check_eq("rst_overrun",    64'(bus.overrun), 64'd0);

    // Large negative product sum, sign must survive in 35 bits
    for (int i = 0; i < 22; i++)
      step(i == 0, 1'b0, 25'h1FFF000, 18'd2047, 25'($urandom), 18'($urandom));
    check_eq("neg_ch0_dout", 64'($signed(bus.ch0_dout)), -64'sd50307072);

    // Random strobes, resets and operands
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 14) == 0, $urandom_range(0, 299) == 0,
           25'($urandom), 18'($urandom), 25'($urandom), 18'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_poly_mac_sched.md
# fir_poly_mac_sched

Slot scheduler and DSP arbiter for the 2-channel polyphase decimating FIR. On each input-sample strobe it runs one sample period of `M` clock slots and broadcasts `tap_addr` to both channels' banks. It grants the single shared DSP multiplier-accumulator to channel 0, then to channel 1, and muxes their operands onto it. It then captures each channel's accumulated result from the DSP output after the pipeline latency and flags it valid.

## Interface
- `M`, 20: slots per sample period (decimation factor)
- `M_LOG2`, 5: width of `tap_addr`
- `K`, 6: MAC slots per channel per period; requires 2·K + DSP_LAT + 1 ≤ M
- `DSP_LAT`, 3: cycles from operands presented to the matching `dsp_p`
- `DSP_A_WIDTH`, 25; `DSP_B_WIDTH`, 18; `DSP_P_WIDTH`, 48: DSP port widths
- `OUTPUT_WIDTH`, 35: result width, taken from `dsp_p[OUTPUT_WIDTH-1:0]`
- `clk` in 1: single clock; all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `sample_en` in 1: one-cycle strobe, start of sample period
- `ch0_a`, `ch1_a` in DSP_A_WIDTH: per-channel tap operands (driven from `tap_addr`)
- `ch0_b`, `ch1_b` in DSP_B_WIDTH: per-channel data operands
- `dsp_p` in DSP_P_WIDTH: shared DSP product/accumulator output
- `tap_addr` out M_LOG2: registered slot index, broadcast to banks
- `ch_sel` out 1: current DSP owner (0/1)
- `mac_en` out 1: DSP slot active
- `dsp_acc` out 1: 1 = accumulate, 0 = load fresh product
- `dsp_a` out DSP_A_WIDTH, `dsp_b` out DSP_B_WIDTH: muxed operands, zero when `mac_en`=0
- `ch0_dout`, `ch1_dout` out OUTPUT_WIDTH: registered results
- `ch0_valid`, `ch1_valid` out 1: one-cycle result strobes
- `overrun` out 1: sticky, sample_en arrived mid-period

## Operation
- FSM states IDLE and RUN. Slot counter `tap_addr` runs 0..M-1 in RUN.
- IDLE + `sample_en`: go to RUN with `tap_addr`=0 on the next cycle.
- RUN, `tap_addr`=M-1:
  - with `sample_en`: `tap_addr`←0, stay RUN (back-to-back periods, no gap).
  - without `sample_en`: go to IDLE, `tap_addr`←0.
- RUN, `tap_addr`<M-1, with `sample_en`: overrun.
  - Set `overrun` (cleared only by `rst`).
  - Restart at `tap_addr`=0.
  - Cancel all pending captures: no valid is emitted for the aborted period.
- Slot map, in RUN only:
  - Slots 0..K-1: `ch_sel`=0, `mac_en`=1.
  - Slots K..2K-1: `ch_sel`=1, `mac_en`=1.
  - Slots ≥2K: `mac_en`=0 and `ch_sel`=0.
  - IDLE: `mac_en`=0, `ch_sel`=0.
- `dsp_acc`=0 on slots 0 and K, and 1 on other MAC slots.
- `dsp_a`/`dsp_b`: combinational mux of the `ch_sel` channel's operands, gated by `mac_en`.
- Capture pipeline: a DSP_LAT-deep tag delay line carries "last MAC of ch0" (slot K-1) and "last MAC of ch1" (slot 2K-1).
  - When a tag exits, register `dsp_p[OUTPUT_WIDTH-1:0]` into that channel's `dout`.
  - Pulse that channel's `valid` in the following cycle.
  - Overrun or `rst` clears the delay line.
- `dout` holds its value between captures.
- Width rules: no rounding or saturation; the upper DSP_P bits are discarded.

## Timing
- Reset: the following clear on the cycle after `rst` is sampled high; reset mid-period aborts the period with no valid.
  - State = IDLE.
  - `tap_addr`, `ch_sel`, `mac_en`, `dsp_acc`, `dsp_a`, `dsp_b` = 0.
  - Both `dout` = 0, both `valid` = 0.
  - `overrun` = 0, tag line = 0.
- `sample_en` in cycle t gives `tap_addr`=0 in cycle t+1.
- Channel 0 owns the DSP in cycles t+1..t+K; channel 1 in t+K+1..t+2K.
- `ch0_valid` in cycle t+K+DSP_LAT+1; `ch1_valid` in cycle t+2K+DSP_LAT+1.
- The parameter constraint keeps both strobes inside the period. Each valid is exactly one cycle and the two never coincide.
- `sample_en` in the same cycle as `rst`: reset wins.

## Test plan
- Defaults, `sample_en` at cycle 0, ch0 operands a=1/b=2 and ch1 operands a=3/b=−1, DSP model with latency 3 → `tap_addr` 0..19 in cycles 1..20; `ch0_valid` at cycle 10 with `ch0_dout`=12; `ch1_valid` at cycle 16 with `ch1_dout`=−18; `dsp_acc` low only at cycles 1 and 7.
- Back-to-back strobes at cycles 0, 20 and 40 → no IDLE gap, `tap_addr` wraps 19→0, three valids per channel, `overrun` stays 0.
- `sample_en` at cycle 0, then again at cycle 8 → `overrun`=1 from cycle 9; `tap_addr`=0 at cycle 9; no `ch0_valid` at cycle 10; next `ch0_valid` at cycle 18 and `ch1_valid` at cycle 24.
- Single strobe, none after → IDLE after slot 19; `mac_en`, `dsp_a`, `dsp_b` = 0 thereafter.
- `rst` asserted at cycle 5 of a period → all outputs 0 at cycle 6; no valid; `overrun` cleared.
- Ch0 operand a=−4096 and b=2047 on all 6 slots → `ch0_dout` = −50307072, sign correct in 35 bits.
